// File: rtl/dcs_pkg.sv
// Shared types and constants for the DCSformer host driver.
//   state_t : transaction FSM states
//   N_ROW/N_COL : input matrix shape; N_IN input bytes, N_BUF total load bytes
//   W_BASE : first weight address in the load buffer
//   DW/OW : stream byte width and result word width
package dcs_pkg;

  localparam int N_ROW  = 8;
  localparam int N_COL  = 16;
  localparam int N_IN   = N_ROW * N_COL;
  localparam int N_BUF  = N_IN + N_ROW;
  localparam int W_BASE = N_IN;
  localparam int DW     = 8;
  localparam int OW     = 32;

  // Stream counter values of the last input beat and the last weight beat.
  localparam logic [7:0] LAST_I = 8'(N_IN - 1);
  localparam logic [7:0] LAST_W = 8'(N_BUF - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_I = 3'd1,
    WAIT_W = 3'd2,
    SEND_W = 3'd3,
    WAIT_O = 3'd4,
    RECV_O = 3'd5,
    FIN    = 3'd6
  } state_t;

endpackage

// File: rtl/dcs_host_driver_if.sv
// Accelerator-side bus of the host driver.
//   i_valid/i_data : input matrix byte stream (driver -> accelerator)
//   w_valid/w_data : weight byte stream (driver -> accelerator)
//   w_ready        : one-cycle "send weights now" pulse (accelerator -> driver)
//   o_valid/o_data : 32-bit result words (accelerator -> driver)
// master = host driver side, slave = accelerator side.
interface dcs_host_driver_if;
  import dcs_pkg::*;

  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          o_valid;
  logic [OW-1:0] o_data;

  modport master (
    output i_valid, i_data, w_valid, w_data,
    input  w_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, w_valid, w_data,
    output w_ready, o_valid, o_data
  );

endinterface

// File: rtl/dcs_load_buf.sv
// 136x8 load RAM: input matrix bytes at 0..127, weights at 128..135.
//   clk     : write clock
//   i_we    : write strobe (caller already qualified state and address range)
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : asynchronous read address (stream counter)
//   o_rdata : read data
// The contents are deliberately not reset.
module dcs_load_buf
  import dcs_pkg::*;
(
  input  logic          clk,
  input  logic          i_we,
  input  logic [7:0]    i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [7:0]    i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:N_BUF-1];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dcs_host_driver.sv
// Host-side transmitter/collector for the DCSformer accelerator.
// Streams 128 input bytes, waits for w_ready, streams 8 weight bytes, then
// captures 8 result words.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_we/addr/wdata  : load-buffer write port (IDLE only, addr <= 135)
//   start              : begin one transaction (IDLE only)
//   i_hold             : bubble request for the input stream
//   busy/done/err      : status (busy while not IDLE, done pulse, sticky err)
//   res_addr/res_data  : combinational read of the result buffer
//   bus                : accelerator-side interface (master modport)
module dcs_host_driver
  import dcs_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [7:0]    cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  input  logic          start,
  input  logic          i_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [2:0]    res_addr,
  output logic [OW-1:0] res_data,
  dcs_host_driver_if.master bus
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic          r_i_valid;
  logic [DW-1:0] r_i_data;
  logic          r_w_valid;
  logic [DW-1:0] r_w_data;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [OW-1:0] r_res [0:N_ROW-1];

  logic          w_we;
  logic [7:0]    w_rd_addr;
  logic [DW-1:0] w_rd_data;
  logic          w_tmo;

  assign w_we = cfg_we && (r_state == IDLE) && (cfg_addr < 8'(N_BUF));
  // In IDLE the first beat is issued straight from the start cycle, so the
  // read port must already point at byte 0 whatever the counter holds.
  assign w_rd_addr = (r_state == IDLE) ? 8'd0 : r_cnt;
  assign w_tmo     = (r_timer == TW'(TIMEOUT));

  dcs_load_buf u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Transaction FSM with all status and stream outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_timer   <= '0;
      r_idx     <= 3'd0;
      r_i_valid <= 1'b0;
      r_i_data  <= '0;
      r_w_valid <= 1'b0;
      r_w_data  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      for (int k = 0; k < N_ROW; k++) begin
        r_res[k] <= '0;
      end
    end else begin
      r_i_valid <= 1'b0;
      r_w_valid <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SEND_I;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            if (!i_hold) begin
              r_i_valid <= 1'b1;
              r_i_data  <= w_rd_data;
              r_cnt     <= 8'd1;
            end else begin
              r_cnt <= 8'd0;
            end
          end
        end
        SEND_I: begin
          if (!i_hold) begin
            r_i_valid <= 1'b1;
            r_i_data  <= w_rd_data;
            r_cnt     <= r_cnt + 8'd1;
            // The counter leaves SEND_I at W_BASE, ready for the weights.
            if (r_cnt == LAST_I) begin
              r_state <= WAIT_W;
              r_timer <= '0;
            end
          end
        end
        WAIT_W: begin
          // w_ready takes priority over a coincident timeout.
          if (bus.w_ready) begin
            r_w_valid <= 1'b1;
            r_w_data  <= w_rd_data;
            r_cnt     <= r_cnt + 8'd1;
            r_state   <= SEND_W;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        SEND_W: begin
          r_w_valid <= 1'b1;
          r_w_data  <= w_rd_data;
          r_cnt     <= r_cnt + 8'd1;
          if (r_cnt == LAST_W) begin
            r_state <= WAIT_O;
            r_timer <= '0;
          end
        end
        WAIT_O: begin
          if (bus.o_valid) begin
            r_res[0] <= bus.o_data;
            r_idx    <= 3'd1;
            r_state  <= RECV_O;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        RECV_O: begin
          if (bus.o_valid) begin
            r_res[r_idx] <= bus.o_data;
            r_idx        <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end else begin
            // Gap in the result burst: keep what was captured, flag error.
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FIN;
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // Protocol violations override anything above, without a state change.
      if (bus.w_ready && (r_state != WAIT_W)) begin
        r_err <= 1'b1;
      end
      if (bus.o_valid && (r_state != WAIT_O) && (r_state != RECV_O)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign res_data    = r_res[res_addr];
  assign bus.i_valid = r_i_valid;
  assign bus.i_data  = r_i_data;
  assign bus.w_valid = r_w_valid;
  assign bus.w_data  = r_w_data;

endmodule

// File: tb/tb_dcs_host_driver.sv
// Self-checking bench for dcs_host_driver with a behavioural DCSformer model.
module tb_dcs_host_driver;
  import dcs_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_main, rst_acc, rst;
  logic        cfg_we, start, i_hold, busy, done, err;
  logic [7:0]  cfg_addr, cfg_wdata;
  logic [2:0]  res_addr;
  logic [31:0] res_data;
  logic        acc_wr, main_wr, acc_ov;
  logic [31:0] acc_od;

  assign rst = rst_main | rst_acc;

  dcs_host_driver_if bus();
  assign bus.w_ready = acc_wr | main_wr;
  assign bus.o_valid = acc_ov;
  assign bus.o_data  = acc_od;

  dcs_host_driver #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .i_hold(i_hold), .busy(busy),
    .done(done), .err(err), .res_addr(res_addr), .res_data(res_data),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  logic [7:0]  ref_buf [0:135];
  logic [31:0] exp_res [0:7];

  // DCSformer function: M = X*X^T, keep entries strictly above their column
  // average, result = masked M times the weight vector.
  task automatic dcs_calc(input logic [7:0] b [0:135], output logic [31:0] r [0:7]);
    int m [0:7][0:7];
    int cs [0:7];
    int acc;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        m[i][j] = 0;
        for (int c = 0; c < 16; c++) m[i][j] += int'(b[i*16+c]) * int'(b[j*16+c]);
      end
    for (int j = 0; j < 8; j++) begin
      cs[j] = 0;
      for (int i = 0; i < 8; i++) cs[j] += m[i][j];
    end
    for (int i = 0; i < 8; i++) begin
      acc = 0;
      for (int j = 0; j < 8; j++)
        if (8 * m[i][j] > cs[j]) acc += m[i][j] * int'(b[128+j]);
      r[i] = acc;
    end
  endtask

  // Accelerator model controls.
  bit          armed = 1'b0;
  int          hold_mode = 0, acc_dly_w = 3, acc_dly_o = 2, gap_at = 8;
  bit          no_wready = 1'b0, rst_at_w = 1'b0;
  int          last_beat_cyc = 0;
  logic [7:0]  acc_buf [0:135];
  logic [31:0] acc_res [0:7];

  // Accelerator model: samples 2 time units after each rising edge.
  initial begin : acc_model
    int phase, ibeat, k, j, dly, hold_cnt;
    logic hold_prev;
    acc_wr = 1'b0; acc_ov = 1'b0; acc_od = 32'd0; i_hold = 1'b0; rst_acc = 1'b0;
    phase = 0; ibeat = 0; k = 0; j = 0; dly = 0; hold_cnt = 0;
    forever begin
      @(posedge clk); #2;
      hold_prev = i_hold;
      acc_wr = 1'b0;
      acc_ov = 1'b0;
      if (!armed) begin
        phase = 0;
        ibeat = 0;
      end else begin
        case (phase)
          0: begin
            chk("i_valid_pattern", 32'(bus.i_valid), 32'(!hold_prev));
            if (bus.i_valid) begin
              chk("i_data", 32'(bus.i_data), 32'(ref_buf[ibeat]));
              acc_buf[ibeat] = bus.i_data;
              ibeat++;
              if (ibeat == 128) begin
                last_beat_cyc = cyc;
                phase = 1;
                dly = acc_dly_w;
              end
            end
          end
          1: begin
            chk("w_valid_idle", 32'(bus.w_valid), 32'd0);
            chk("i_valid_after", 32'(bus.i_valid), 32'd0);
            if (!no_wready) begin
              if (dly == 0) begin
                acc_wr = 1'b1;
                phase = 2;
                k = 0;
              end else dly--;
            end
          end
          2: begin
            chk("w_valid", 32'(bus.w_valid), 32'd1);
            chk("w_data", 32'(bus.w_data), 32'(ref_buf[128+k]));
            acc_buf[128+k] = bus.w_data;
            if (rst_at_w && k == 4) begin
              rst_acc = 1'b1;
              phase = 6;
            end else begin
              k++;
              if (k == 8) begin
                phase = 3;
                dly = acc_dly_o;
              end
            end
          end
          3: begin
            chk("w_valid_end", 32'(bus.w_valid), 32'd0);
            if (dly == 0) begin
              dcs_calc(acc_buf, acc_res);
              j = 0;
              phase = 4;
            end else dly--;
          end
          4: begin
            if (j == gap_at) phase = 5;
            else begin
              acc_ov = 1'b1;
              acc_od = acc_res[j];
              j++;
              if (j == 8) phase = 5;
            end
          end
          6: begin
            chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            rst_acc = 1'b0;
            phase = 5;
          end
          default: ;
        endcase
      end
      case (hold_mode)
        1: begin
          hold_cnt++;
          i_hold = (hold_cnt % 3 == 0);
        end
        2: i_hold = ($urandom_range(0, 3) == 0);
        default: i_hold = 1'b0;
      endcase
    end
  end

  function automatic logic [7:0] pat_byte(input int kind, input int a);
    case (kind)
      0: return 8'(a);
      1: return (a < 128) ? (((a / 16) == (a % 16)) ? 8'd1 : 8'd0) : 8'(a - 127);
      2: return 8'd1;
      default: return (a < 128) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 9));
    endcase
  endfunction

  task automatic load_pat(input int kind);
    logic [7:0] d;
    for (int a = 0; a < 136; a++) begin
      d = pat_byte(kind, a);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 8'(a); cfg_wdata = d;
      ref_buf[a] = d;
    end
    // Out-of-range addresses must be ignored.
    @(negedge clk); cfg_addr = 8'd136; cfg_wdata = 8'($urandom);
    @(negedge clk); cfg_addr = 8'd255; cfg_wdata = 8'($urandom);
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic check_res(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      res_addr = 3'(i);
      #1;
      chk(tag, res_data, exp_res[i]);
    end
  endtask

  // Run one transaction; abort=1 expects the model to reset the DUT midway.
  task automatic run_trx(input string tag, input logic exp_err, input bit abort,
                         input bit bwr, output int done_cyc);
    int seen_done, cy;
    bit fin;
    seen_done = 0; cy = 0; fin = 1'b0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_err_clr"}, 32'(err), 32'd0);
    while (!fin && cy < 3000) begin
      if (bwr && cy == 20) begin
        cfg_we = 1'b1; cfg_addr = 8'd5; cfg_wdata = ~ref_buf[5];
      end else cfg_we = 1'b0;
      @(negedge clk);
      cy++;
      if (done) begin
        seen_done++;
        done_cyc = cyc;
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
      end
      if (!busy) fin = 1'b1;
    end
    cfg_we = 1'b0;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_done_cnt"}, 32'(seen_done), abort ? 32'd0 : 32'd1);
    if (!abort) chk({tag, "_busy_drop"}, 32'(cyc - done_cyc), 32'd1);
    armed = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_no_extra_done"}, 32'(done), 32'd0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] r [0:7];
    int dc;
    rst_main = 1'b1; cfg_we = 1'b0; cfg_addr = 8'd0; cfg_wdata = 8'd0;
    start = 1'b0; main_wr = 1'b0; res_addr = 3'd0;
    for (int i = 0; i < 8; i++) exp_res[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_i_valid", 32'(bus.i_valid), 32'd0);
    chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
    chk("rst_i_data", 32'(bus.i_data), 32'd0);
    chk("rst_w_data", 32'(bus.w_data), 32'd0);
    rst_main = 1'b0;
    check_res("rst_res");

    // Framing with a counting pattern.
    load_pat(0); hold_mode = 0; acc_dly_w = 5; acc_dly_o = 3;
    run_trx("frame", 1'b0, 1'b0, 1'b0, dc);
    dcs_calc(ref_buf, r);
    for (int i = 0; i < 8; i++) exp_res[i] = r[i];
    check_res("frame_res");

    // Identity matrix, weights 1..8.
    load_pat(1);
    run_trx("ident", 1'b0, 1'b0, 1'b0, dc);
    for (int i = 0; i < 8; i++) exp_res[i] = 32'(i + 1);
    check_res("ident_res");

    // All ones: strict compare removes everything.
    load_pat(2);
    run_trx("ones", 1'b0, 1'b0, 1'b0, dc);
    for (int i = 0; i < 8; i++) exp_res[i] = 32'd0;
    check_res("ones_res");

    // Identity with a bubble every third cycle.
    load_pat(1); hold_mode = 1;
    run_trx("bubble", 1'b0, 1'b0, 1'b0, dc);
    for (int i = 0; i < 8; i++) exp_res[i] = 32'(i + 1);
    check_res("bubble_res");
    hold_mode = 0;

    // No w_ready: timeout, results untouched.
    no_wready = 1'b1;
    run_trx("tmo", 1'b1, 1'b0, 1'b0, dc);
    chk("tmo_latency", 32'(dc - last_beat_cyc), 32'd16);
    no_wready = 1'b0;
    check_res("tmo_res");

    // Result burst gap after 3 words.
    load_pat(3); gap_at = 3;
    run_trx("gap", 1'b1, 1'b0, 1'b0, dc);
    dcs_calc(ref_buf, r);
    for (int i = 0; i < 3; i++) exp_res[i] = r[i];
    check_res("gap_res");
    gap_at = 8;

    // Stray w_ready in IDLE sets err; the next start clears it.
    @(negedge clk); main_wr = 1'b1;
    @(negedge clk); main_wr = 1'b0;
    chk("proto_err", 32'(err), 32'd1);
    chk("proto_busy", 32'(busy), 32'd0);

    // Reset during weight beat 4.
    rst_at_w = 1'b1;
    run_trx("abort", 1'b0, 1'b1, 1'b0, dc);
    rst_at_w = 1'b0;
    for (int i = 0; i < 8; i++) exp_res[i] = 32'd0;
    check_res("abort_res");

    // Clean run afterwards with a write attempted while busy.
    run_trx("after", 1'b0, 1'b0, 1'b1, dc);
    dcs_calc(ref_buf, r);
    for (int i = 0; i < 8; i++) exp_res[i] = r[i];
    check_res("after_res");

    // Randomised trials; the first one also re-streams the buffer untouched.
    hold_mode = 2;
    for (int t = 0; t < 3; t++) begin
      if (t > 0) load_pat(3);
      acc_dly_w = $urandom_range(0, 10);
      acc_dly_o = $urandom_range(0, 10);
      run_trx("rand", 1'b0, 1'b0, 1'b0, dc);
      dcs_calc(ref_buf, r);
      for (int i = 0; i < 8; i++) exp_res[i] = r[i];
      check_res("rand_res");
    end
    hold_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
